// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the clk_sys reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RST_POR  = 2'd0,
    RST_LOCK = 2'd1,
    RST_EXT  = 2'd2,
    RST_SW   = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_e;

  // Width of the hold and stage-gap counters.
  localparam int CNT_W = 16;

  // Lock loss outranks the button, which outranks a software request.
  function automatic rst_cause_e fault_cause(input logic lock_lost,
                                             input logic ext_asserted);
    if (lock_lost)         return RST_LOCK;
    else if (ext_asserted) return RST_EXT;
    else                   return RST_SW;
  endfunction

endpackage

// File: rtl/rst_debounce_sync.sv
// Synchroniser chain followed by a debounce filter. With DEBOUNCE_CYCLES <= 1
// the synchronised value is passed straight through so no latency is added.
module rst_debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic async_i,
  output logic sync_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Metastability chain; the input enters at bit 0.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_s != deb_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = sync_s;
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      deb_q <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign sync_o = (DEBOUNCE_CYCLES <= 1) ? sync_s : deb_q;

endmodule

// File: rtl/rst_seq_xil7series.sv
// Staged per-domain reset sequencer behind the 7-series MMCM.
//
// state   | meaning
// HOLD    | all domains in reset, waiting for HOLD_CYCLES of good conditions
// RELEASE | releasing domains one by one, STAGE_GAP cycles apart
// RUN     | all domains released, watching for a fault
module rst_seq_xil7series
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int NUM_DOMAINS     = 2,
  parameter int STAGE_GAP       = 8
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic                   pll_locked_i,
  input  logic                   ext_rst_ni,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_out_no,
  output logic                   rst_done_o,
  output logic [1:0]             rst_cause_o,
  output logic [7:0]             lock_loss_cnt_o
);

  localparam int DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic locked_s, btn_rel_s, good, fault;

  rst_debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1),
    .RESET_VAL      (1'b0)
  ) u_lock_sync (
    .clk_sys(clk_sys),
    .rst_sys(rst_sys),
    .async_i(pll_locked_i),
    .sync_o (locked_s)
  );

  // Button reads as pressed (0) out of reset until it proves otherwise.
  rst_debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b0)
  ) u_btn_sync (
    .clk_sys(clk_sys),
    .rst_sys(rst_sys),
    .async_i(ext_rst_ni),
    .sync_o (btn_rel_s)
  );

  rst_seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic [CNT_W-1:0]       stage_q, stage_d;
  logic [DOM_W-1:0]       dom_q, dom_d;
  logic [NUM_DOMAINS-1:0] out_q, out_d;
  logic                   done_q, done_d;
  rst_cause_e             cause_q, cause_d;
  logic [7:0]             lcnt_q, lcnt_d;
  logic                   locked_prev_q;

  assign good  = locked_s & btn_rel_s;
  assign fault = ~locked_s | ~btn_rel_s | sw_rst_req_i;

  // Next-state, staged release and telemetry.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stage_d = stage_q;
    dom_d   = dom_q;
    out_d   = out_q;
    done_d  = done_q;
    cause_d = cause_q;
    lcnt_d  = lcnt_q;

    if (locked_prev_q && !locked_s && lcnt_q != 8'hFF) lcnt_d = lcnt_q + 8'd1;

    case (state_q)
      HOLD: begin
        out_d   = '0;
        done_d  = 1'b0;
        stage_d = '0;
        dom_d   = '0;
        if (!good || sw_rst_req_i) begin
          hold_d = '0;
        end else if (hold_q == CNT_W'(HOLD_CYCLES - 1)) begin
          hold_d = '0;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            out_d   = '1;
            done_d  = 1'b1;
          end else begin
            state_d  = RELEASE;
            out_d[0] = 1'b1;
            dom_d    = DOM_W'(1);
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (fault) begin
          state_d = HOLD;
          out_d   = '0;
          done_d  = 1'b0;
          hold_d  = '0;
          stage_d = '0;
          dom_d   = '0;
          cause_d = fault_cause(~locked_s, ~btn_rel_s);
        end else if (state_q == RELEASE) begin
          if (stage_q == CNT_W'(STAGE_GAP - 1)) begin
            stage_d      = '0;
            out_d[dom_q] = 1'b1;
            if (dom_q == DOM_W'(NUM_DOMAINS - 1)) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              dom_d = dom_q + 1'b1;
            end
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q       <= HOLD;
      hold_q        <= '0;
      stage_q       <= '0;
      dom_q         <= '0;
      out_q         <= '0;
      done_q        <= 1'b0;
      cause_q       <= RST_POR;
      lcnt_q        <= '0;
      locked_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      stage_q       <= stage_d;
      dom_q         <= dom_d;
      out_q         <= out_d;
      done_q        <= done_d;
      cause_q       <= cause_d;
      lcnt_q        <= lcnt_d;
      locked_prev_q <= locked_s;
    end
  end

  assign rst_out_no      = out_q;
  assign rst_done_o      = done_q;
  assign rst_cause_o     = cause_q;
  assign lock_loss_cnt_o = lcnt_q;

endmodule

// File: tb/tb_rst_seq_xil7series.sv
// Directed bench: a vector table walks the sequencer through power-up, lock
// loss, button presses, software resets and mid-release faults; hand-written
// sequences cover counter saturation and a synchronous reset while running.
module tb_rst_seq_xil7series;

  logic       clk_sys = 1'b0;
  logic       rst_sys, pll_locked_i, ext_rst_ni, sw_rst_req_i;
  logic [1:0] rst_out_no;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;
  logic [7:0] lock_loss_cnt_o;

  always #5 clk_sys = ~clk_sys;

  rst_seq_xil7series #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16),
    .NUM_DOMAINS    (2),
    .STAGE_GAP      (8)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .pll_locked_i   (pll_locked_i),
    .ext_rst_ni     (ext_rst_ni),
    .sw_rst_req_i   (sw_rst_req_i),
    .rst_out_no     (rst_out_no),
    .rst_done_o     (rst_done_o),
    .rst_cause_o    (rst_cause_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  // Inputs held for cyc rising edges, then outputs compared.
  typedef struct {
    int         cyc;
    logic       lk;
    logic       ex;
    logic       sw;
    logic [1:0] exp_out;
    logic       exp_done;
    logic [1:0] exp_cause;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int cyc, input logic lk, input logic ex, input logic sw,
                     input logic [1:0] o, input logic d, input logic [1:0] c,
                     input logic [7:0] n);
    vec_t v;
    v.cyc = cyc; v.lk = lk; v.ex = ex; v.sw = sw;
    v.exp_out = o; v.exp_done = d; v.exp_cause = c; v.exp_cnt = n;
    vecs.push_back(v);
  endtask

  function automatic logic [12:0] obs();
    return {rst_out_no, rst_done_o, rst_cause_o, lock_loss_cnt_o};
  endfunction

  task automatic check_vec(input string name, input int idx,
                           input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got out=%b done=%b cause=%0d cnt=%0d want out=%b done=%b cause=%0d cnt=%0d",
               name, idx, act[12:11], act[10], act[9:8], act[7:0],
               exp[12:11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: button releases 2+4 edges after reset, domain 0 at edge 22, domain 1 at 30.
    add(21, 1, 1, 0, 2'b00, 0, 2'd0, 8'd0);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd0, 8'd0);
    add( 7, 1, 1, 0, 2'b01, 0, 2'd0, 8'd0);
    add( 1, 1, 1, 0, 2'b11, 1, 2'd0, 8'd0);
    // One-cycle lock loss: outputs drop on the third edge, then 16 + 8 re-sequence.
    add( 1, 0, 1, 0, 2'b11, 1, 2'd0, 8'd0);
    add( 1, 1, 1, 0, 2'b11, 1, 2'd0, 8'd0);
    add( 1, 1, 1, 0, 2'b00, 0, 2'd1, 8'd1);
    add(15, 1, 1, 0, 2'b00, 0, 2'd1, 8'd1);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd1, 8'd1);
    add( 8, 1, 1, 0, 2'b11, 1, 2'd1, 8'd1);
    // Button bounce of 3 cycles is filtered out.
    add( 3, 1, 0, 0, 2'b11, 1, 2'd1, 8'd1);
    add(10, 1, 1, 0, 2'b11, 1, 2'd1, 8'd1);
    // Held press: still running after 6 edges, reset on the 7th.
    add( 6, 1, 0, 0, 2'b11, 1, 2'd1, 8'd1);
    add( 1, 1, 0, 0, 2'b00, 0, 2'd2, 8'd1);
    add( 3, 1, 0, 0, 2'b00, 0, 2'd2, 8'd1);
    // Release: debounced at edge 6 after pin high, domain 0 16 edges later.
    add(21, 1, 1, 0, 2'b00, 0, 2'd2, 8'd1);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd2, 8'd1);
    add( 8, 1, 1, 0, 2'b11, 1, 2'd2, 8'd1);
    // Software pulse: reset next edge, domain 0 16 edges later.
    add( 1, 1, 1, 1, 2'b00, 0, 2'd3, 8'd1);
    add(15, 1, 1, 0, 2'b00, 0, 2'd3, 8'd1);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd3, 8'd1);
    add( 8, 1, 1, 0, 2'b11, 1, 2'd3, 8'd1);
    // Lock loss and software request reach the FSM together: lock wins.
    add( 1, 0, 1, 0, 2'b11, 1, 2'd3, 8'd1);
    add( 1, 1, 1, 0, 2'b11, 1, 2'd3, 8'd1);
    add( 1, 1, 1, 1, 2'b00, 0, 2'd1, 8'd2);
    add(15, 1, 1, 0, 2'b00, 0, 2'd1, 8'd2);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd1, 8'd2);
    // Lock loss with only domain 0 released: it re-asserts, hold restarts.
    add( 1, 0, 1, 0, 2'b01, 0, 2'd1, 8'd2);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd1, 8'd2);
    add( 1, 1, 1, 0, 2'b00, 0, 2'd1, 8'd3);
    add(15, 1, 1, 0, 2'b00, 0, 2'd1, 8'd3);
    add( 1, 1, 1, 0, 2'b01, 0, 2'd1, 8'd3);
    add( 8, 1, 1, 0, 2'b11, 1, 2'd1, 8'd3);

    rst_sys = 1'b1; pll_locked_i = 1'b1; ext_rst_ni = 1'b1; sw_rst_req_i = 1'b0;
    tick(3);
    check_vec("por", 0, obs(), 13'd0);

    rst_sys = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      pll_locked_i = vecs[i].lk;
      ext_rst_ni   = vecs[i].ex;
      sw_rst_req_i = vecs[i].sw;
      tick(vecs[i].cyc);
      check_vec("vec", i, obs(),
                {vecs[i].exp_out, vecs[i].exp_done, vecs[i].exp_cause, vecs[i].exp_cnt});
    end

    // 300 more falling edges on top of the 3 seen: counter must stick at 255.
    for (int p = 0; p < 300; p++) begin
      pll_locked_i = 1'b0; tick(1);
      pll_locked_i = 1'b1; tick(1);
    end
    tick(4);
    check_val("lock_cnt_sat", int'(lock_loss_cnt_o), 255);
    check_val("cause_after_pulses", int'(rst_cause_o), 1);

    for (int i = 0; i < 100 && !rst_done_o; i++) tick(1);
    check_val("rerun_done", int'(rst_done_o), 1);

    rst_sys = 1'b1;
    tick(1);
    check_vec("rst_mid_run", 0, obs(), 13'd0);
    rst_sys = 1'b0;
    tick(1);
    check_vec("post_rst_hold", 0, obs(), 13'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
